// File: rtl/vga_reg_scheduler.sv
// Frame-synchronous round-robin owner of a single hex register overlay.
// Values, zoom and position change only on a VS rising edge, so the overlay never tears mid-frame.
module vga_reg_scheduler #(
    parameter int N_REQ  = 4,
    parameter int DWELL  = 60,
    parameter int X_BASE = 16,
    parameter int Y_BASE = 16
) (
    input  logic                 px_clk,
    input  logic                 reset,
    input  logic [25:0]          strRGB_i,
    input  logic [2:0]           zoom_i,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  reg_data,
    output logic [N_REQ-1:0]     ack,
    output logic [15:0]          register_o,
    output logic [9:0]           x_pos_o,
    output logic [9:0]           y_pos_o,
    output logic [2:0]           zoom_o,
    output logic [2:0]           sel_o,
    output logic                 valid_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [0:0]       state;
    logic             vsReg;
    logic             vsPrev;
    logic [1:0]       primed;
    logic             tick;
    logic [DW-1:0]    dwell;
    logic [15:0]      regWord [N_REQ];

    logic             ownerReq;
    logic             found;
    logic             refresh;
    logic [2:0]       winIdx;
    logic [2:0]       grantIdx;
    logic [15:0]      grantData;
    logic [15:0]      glyphW;
    logic [9:0]       yNext;
    logic [N_REQ-1:0] grantOneHot;
    logic             unusedRgb;
    int               cand;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign regWord[gi] = reg_data[16*gi +: 16];
        end
    endgenerate

    assign unusedRgb = ^{strRGB_i[25:2], strRGB_i[0]};

    // primed blocks a false edge when VS is already high as reset is released
    assign tick    = vsReg & ~vsPrev & primed[1];
    assign x_pos_o = 10'(X_BASE);
    assign glyphW  = 16'd8 << zoom_i;

    always_comb begin
        ownerReq    = 1'b0;
        found       = 1'b0;
        winIdx      = sel_o;
        grantData   = '0;
        grantOneHot = '0;
        cand        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (k == int'(sel_o)) ownerReq = req[k];
        end
        // Search starts just after the owner, so the owner itself is checked last
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(sel_o) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && k == cand && req[k]) begin
                    found  = 1'b1;
                    winIdx = 3'(k);
                end
            end
        end
        refresh  = (state == SHOW) && ownerReq && (dwell != '0);
        grantIdx = refresh ? sel_o : winIdx;
        for (int k = 0; k < N_REQ; k++) begin
            if (k == int'(grantIdx)) begin
                grantData      = regWord[k];
                grantOneHot[k] = 1'b1;
            end
        end
        // Row pitch is the glyph width plus a quarter gap; wraps modulo 1024
        yNext = 10'(16'(Y_BASE) + 16'(grantIdx) * (glyphW + (glyphW >> 2)));
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vsReg      <= 1'b0;
            vsPrev     <= 1'b0;
            primed     <= 2'b00;
            dwell      <= '0;
            ack        <= '0;
            register_o <= '0;
            y_pos_o    <= 10'(Y_BASE);
            zoom_o     <= '0;
            sel_o      <= 3'(N_REQ - 1);
            valid_o    <= 1'b0;
        end else begin
            vsReg  <= strRGB_i[1];
            vsPrev <= vsReg;
            primed <= {primed[0], 1'b1};
            ack    <= '0;
            if (tick) begin
                if (refresh || found) begin
                    register_o <= grantData;
                    zoom_o     <= zoom_i;
                    y_pos_o    <= yNext;
                    ack        <= grantOneHot;
                    state      <= SHOW;
                    valid_o    <= 1'b1;
                    if (refresh) begin
                        dwell <= dwell - DW'(1);
                    end else begin
                        sel_o <= winIdx;
                        dwell <= DW'(DWELL - 1);
                    end
                end else begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_reg_scheduler.sv
// Scoreboard bench for vga_reg_scheduler: each frame's expected grant is queued up front
// and a negedge monitor checks it whenever an ack pulse appears.
module tb_vga_reg_scheduler;
    logic        clk;
    logic        rst;
    logic [25:0] rgb;
    logic [2:0]  zoomIn;
    logic [3:0]  req;
    logic [63:0] regData;
    logic [3:0]  ack;
    logic [15:0] registerOut;
    logic [9:0]  xPos;
    logic [9:0]  yPos;
    logic [2:0]  zoomOut;
    logic [2:0]  sel;
    logic        valid;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
        logic [9:0]  y;
        logic [2:0]  zoom;
        logic [3:0]  ack;
    } exp_t;
    exp_t sbQ[$];
    exp_t monEntry;

    vga_reg_scheduler #(.N_REQ(4), .DWELL(2), .X_BASE(16), .Y_BASE(16)) dut (
        .px_clk(clk), .reset(rst), .strRGB_i(rgb), .zoom_i(zoomIn), .req(req),
        .reg_data(regData), .ack(ack), .register_o(registerOut), .x_pos_o(xPos),
        .y_pos_o(yPos), .zoom_o(zoomOut), .sel_o(sel), .valid_o(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end else begin
            $display("ok   %s value=%0h", nm, act);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic [15:0] d, input logic [9:0] y,
                        input logic [2:0] z, input logic [3:0] a);
        exp_t e;
        e.sel = s; e.data = d; e.y = y; e.zoom = z; e.ack = a;
        sbQ.push_back(e);
    endtask

    task automatic frame();
        @(negedge clk) rgb[1] = 1'b1;
        repeat (3) @(negedge clk);
        rgb[1] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && ack != 4'b0) begin
            if (sbQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack actual=%b expected=none", ack);
            end else begin
                monEntry = sbQ.pop_front();
                chk("mon_sel",   32'(sel),         32'(monEntry.sel));
                chk("mon_data",  32'(registerOut), 32'(monEntry.data));
                chk("mon_ypos",  32'(yPos),        32'(monEntry.y));
                chk("mon_zoom",  32'(zoomOut),     32'(monEntry.zoom));
                chk("mon_ack",   32'(ack),         32'(monEntry.ack));
                chk("mon_valid", 32'(valid),       32'd1);
            end
        end
    end

    initial begin
        rst = 1'b1; rgb = '0; zoomIn = 3'd0; req = 4'b0; regData = '0;
        repeat (2) @(negedge clk);
        chk("rst_reg",   32'(registerOut), 32'h0);
        chk("rst_x",     32'(xPos),        32'd16);
        chk("rst_y",     32'(yPos),        32'd16);
        chk("rst_zoom",  32'(zoomOut),     32'd0);
        chk("rst_sel",   32'(sel),         32'd3);
        chk("rst_valid", 32'(valid),       32'd0);
        chk("rst_ack",   32'(ack),         32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // T1: no requests, overlay stays off
        for (int i = 0; i < 3; i++) begin
            frame();
            chk("t1_valid", 32'(valid),       32'd0);
            chk("t1_reg",   32'(registerOut), 32'h0);
        end

        // T2: single requester, latency and mid-frame hold
        regData[15:0] = 16'hBEEF; zoomIn = 3'd1; req = 4'b0001;
        push(3'd0, 16'hBEEF, 10'd16, 3'd1, 4'b0001);
        @(negedge clk) rgb[1] = 1'b1;
        @(negedge clk);
        chk("t2_lat_valid", 32'(valid), 32'd0);
        chk("t2_lat_ack",   32'(ack),   32'd0);
        @(negedge clk);
        chk("t2_valid", 32'(valid), 32'd1);
        @(negedge clk);
        chk("t2_ack_once", 32'(ack), 32'd0);
        rgb[1] = 1'b0;
        regData[15:0] = 16'h1234;
        repeat (5) @(negedge clk);
        chk("t2_hold", 32'(registerOut), 32'hBEEF);

        // T3: DWELL=2 alternation between requesters 1 and 3
        zoomIn = 3'd0; req = 4'b1010;
        regData[31:16] = 16'h1111; regData[47:32] = 16'h2222; regData[63:48] = 16'h3333;
        push(3'd1, 16'h1111, 10'd26, 3'd0, 4'b0010); frame(); chk("t3_sel_f1", 32'(sel), 32'd1);
        push(3'd1, 16'h1111, 10'd26, 3'd0, 4'b0010); frame(); chk("t3_sel_f2", 32'(sel), 32'd1);
        push(3'd3, 16'h3333, 10'd46, 3'd0, 4'b1000); frame(); chk("t3_sel_f3", 32'(sel), 32'd3);
        push(3'd3, 16'h3333, 10'd46, 3'd0, 4'b1000); frame(); chk("t3_sel_f4", 32'(sel), 32'd3);
        push(3'd1, 16'h1111, 10'd26, 3'd0, 4'b0010); frame(); chk("t3_sel_f5", 32'(sel), 32'd1);

        // T4: owner 3 drops mid-dwell, then everybody drops
        push(3'd1, 16'h1111, 10'd26, 3'd0, 4'b0010); frame();
        push(3'd3, 16'h3333, 10'd46, 3'd0, 4'b1000); frame();
        req = 4'b0001;
        push(3'd0, 16'h1234, 10'd16, 3'd0, 4'b0001); frame();
        chk("t4_sel", 32'(sel), 32'd0);
        req = 4'b0000;
        frame();
        chk("t4_idle_valid", 32'(valid), 32'd0);
        chk("t4_idle_ack",   32'(ack),   32'd0);

        // T5: position of requester 2 at zoom 2
        req = 4'b0100; zoomIn = 3'd2;
        push(3'd2, 16'h2222, 10'd96, 3'd2, 4'b0100); frame();
        chk("t5_y",     32'(yPos),  32'd96);
        chk("t5_x",     32'(xPos),  32'd16);
        chk("t5_valid", 32'(valid), 32'd1);

        // T6: asynchronous reset while showing, then regrant
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_reg",   32'(registerOut), 32'h0);
        chk("t6_sel",   32'(sel),         32'd3);
        chk("t6_valid", 32'(valid),       32'd0);
        chk("t6_y",     32'(yPos),        32'd16);
        chk("t6_zoom",  32'(zoomOut),     32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        push(3'd2, 16'h2222, 10'd96, 3'd2, 4'b0100); frame();
        chk("t6_regrant_sel", 32'(sel), 32'd2);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
